// File: rtl/arith_sequencer_if.sv
// Command/response bundle between control logic and the arithmetic sequencer.
// No latency of its own; pure wiring.
// Backpressure via cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes.
interface arith_sequencer_if #(
    parameter int W = 4
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*W-1:0] rsp_data;
    logic           rsp_carry;
    logic           busy;

    // Controller side: issues commands, consumes responses.
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_carry, busy
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_carry, busy
    );
endinterface

// File: rtl/arith_sequencer.sv
// Multi-cycle ADD/SUB/MUL/DIV sequencer built from single-cycle add/sub/shift steps.
// Latency: k+1 cycles from accept to rsp_valid (k=1 ADD/SUB/DIV-by-0, k=W MUL/DIV).
// One op in flight; cmd_ready only in IDLE, result held in DONE until rsp_ready.
module arith_sequencer #(
    parameter int W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    arith_sequencer_if.slave io_seq
);
    // Counter indexes operand bits 0..W-1; W must be at least 2.
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [1:0]     r_op;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_rem;
    logic [W-1:0]   r_quo;
    logic [2*W-1:0] r_res;
    logic           r_carry;

    logic           w_cmd_ready;
    logic           w_rsp_valid;
    logic           w_busy;
    logic           w_accept;
    logic           w_last;
    logic           w_div_zero;
    logic [W:0]     w_sum;
    logic [W:0]     w_diff;
    logic [CW-1:0]  w_div_idx;
    logic [W:0]     w_rem_sh;
    logic [W:0]     w_rem_sub;
    logic [2*W-1:0] w_acc_nxt;
    logic [W-1:0]   w_rem_nxt;
    logic [W-1:0]   w_quo_nxt;
    logic [2*W-1:0] w_res_nxt;
    logic           w_carry_nxt;

    assign w_accept   = io_seq.cmd_valid & w_cmd_ready;
    assign w_div_zero = (r_b == '0);

    // ADD, SUB and divide-by-zero finish in one step; MUL/DIV walk all W bits.
    assign w_last = (r_op == OP_ADD) || (r_op == OP_SUB) ||
                    ((r_op == OP_DIV) && w_div_zero) ||
                    (r_cnt == CW'(W - 1));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state and handshake outputs, all decoded from registered state.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                w_busy      = 1'b0;
                if (io_seq.cmd_valid) w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_rsp_valid = 1'b1;
                if (io_seq.rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One primitive step: add/sub, shift-add multiply bit, restoring divide bit.
    always_comb begin
        w_sum     = {1'b0, r_a} + {1'b0, r_b};
        w_diff    = {1'b0, r_a} - {1'b0, r_b};
        // Dividend bits are consumed MSB first.
        w_div_idx = CW'(W - 1) - r_cnt;
        w_rem_sh  = {r_rem, r_a[w_div_idx]};
        w_rem_sub = w_rem_sh - {1'b0, r_b};

        w_acc_nxt = r_acc;
        if (r_b[r_cnt]) w_acc_nxt = r_acc + ({{W{1'b0}}, r_a} << r_cnt);

        w_rem_nxt = w_rem_sh[W-1:0];
        w_quo_nxt = {r_quo[W-2:0], 1'b0};
        if (w_rem_sh >= {1'b0, r_b}) begin
            w_rem_nxt    = w_rem_sub[W-1:0];
            w_quo_nxt[0] = 1'b1;
        end

        w_res_nxt   = '0;
        w_carry_nxt = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res_nxt   = {{W{1'b0}}, w_sum[W-1:0]};
                w_carry_nxt = w_sum[W];
            end
            OP_SUB: begin
                // Borrow out of the W+1-bit difference is exactly a<b.
                w_res_nxt   = {{W{1'b0}}, w_diff[W-1:0]};
                w_carry_nxt = w_diff[W];
            end
            OP_MUL: begin
                w_res_nxt = w_acc_nxt;
            end
            default: begin
                if (w_div_zero) begin
                    w_res_nxt   = {r_a, {W{1'b1}}};
                    w_carry_nxt = 1'b1;
                end else begin
                    w_res_nxt = {w_rem_nxt, w_quo_nxt};
                end
            end
        endcase
    end

    // Operand capture on accept, iteration state during EXEC, result latch on last step.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op    <= OP_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= io_seq.cmd_op;
                        r_a   <= io_seq.cmd_a;
                        r_b   <= io_seq.cmd_b;
                        r_cnt <= '0;
                        r_acc <= '0;
                        r_rem <= '0;
                        r_quo <= '0;
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt + CW'(1);
                    r_acc <= w_acc_nxt;
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    if (w_last) begin
                        r_res   <= w_res_nxt;
                        r_carry <= w_carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_seq.cmd_ready = w_cmd_ready;
    assign io_seq.rsp_valid = w_rsp_valid;
    assign io_seq.busy      = w_busy;
    assign io_seq.rsp_data  = r_res;
    assign io_seq.rsp_carry = r_carry;
endmodule

// File: tb/tb_arith_sequencer.sv
// Directed plus randomized bench for arith_sequencer at W=4.
// Cycle-exact checks of handshake timing against an arithmetic reference model.
// Exercises response backpressure, back-to-back commands and mid-operation reset.
module tb_arith_sequencer;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    logic [1:0] nxt_op;
    logic [3:0] nxt_a;
    logic [3:0] nxt_b;

    arith_sequencer_if #(.W(4)) bus ();

    arith_sequencer #(.W(4)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_seq  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain-arithmetic reference: result, flag and number of EXEC cycles.
    task automatic model(input logic [1:0] op, input int a, input int b,
                         output logic [7:0] d, output logic c, output int k);
        case (op)
            2'd0: begin d = 8'((a + b) % 16);      c = (a + b) > 15; k = 1; end
            2'd1: begin d = 8'((a - b + 16) % 16); c = (a < b);      k = 1; end
            2'd2: begin d = 8'(a * b);             c = 1'b0;         k = 4; end
            default: begin
                if (b == 0) begin d = 8'(a * 16 + 15); c = 1'b1; k = 1; end
                else begin d = 8'((a % b) * 16 + (a / b)); c = 1'b0; k = 4; end
            end
        endcase
    endtask

    // Issue one command in the current cycle C and check every cycle until H+1.
    // wait_cyc: cycles rsp_ready stays low after rsp_valid rises.
    // keep: leave cmd_valid high after accept, presenting nxt_* as the next command.
    task automatic do_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input int wait_cyc, input bit keep);
        logic [7:0] ed;
        logic       ec;
        int         k;
        model(op, int'(a), int'(b), ed, ec, k);
        chk("cmd_ready_at_C", 16'(bus.cmd_ready), 16'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.rsp_ready = (wait_cyc == 0);
        tick();
        if (keep) begin
            bus.cmd_op = nxt_op;
            bus.cmd_a  = nxt_a;
            bus.cmd_b  = nxt_b;
        end else begin
            bus.cmd_valid = 1'b0;
            bus.cmd_op    = 2'($urandom);
            bus.cmd_a     = 4'($urandom);
            bus.cmd_b     = 4'($urandom);
        end
        for (int i = 1; i <= k; i++) begin
            chk("rsp_valid_exec", 16'(bus.rsp_valid), 16'd0);
            chk("cmd_ready_exec", 16'(bus.cmd_ready), 16'd0);
            chk("busy_exec",      16'(bus.busy),      16'd1);
            tick();
        end
        chk("rsp_valid_rise", 16'(bus.rsp_valid), 16'd1);
        chk("rsp_data",       16'(bus.rsp_data),  16'(ed));
        chk("rsp_carry",      16'(bus.rsp_carry), 16'(ec));
        chk("busy_done",      16'(bus.busy),      16'd1);
        for (int i = 0; i < wait_cyc; i++) begin
            bus.cmd_valid = i[0];
            bus.cmd_op    = 2'($urandom);
            tick();
            chk("rsp_valid_hold", 16'(bus.rsp_valid), 16'd1);
            chk("rsp_data_hold",  16'(bus.rsp_data),  16'(ed));
            chk("rsp_carry_hold", 16'(bus.rsp_carry), 16'(ec));
            chk("cmd_ready_hold", 16'(bus.cmd_ready), 16'd0);
        end
        if (wait_cyc > 0) begin
            bus.cmd_valid = 1'b0;
            bus.rsp_ready = 1'b1;
        end
        tick();
        chk("rsp_valid_after_hs", 16'(bus.rsp_valid), 16'd0);
        chk("cmd_ready_after_hs", 16'(bus.cmd_ready), 16'd1);
        chk("busy_after_hs",      16'(bus.busy),      16'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        nxt_op = 2'd0;
        nxt_a  = 4'd0;
        nxt_b  = 4'd0;

        // Reset with a command pending: it must be ignored.
        reset         = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        bus.cmd_a     = 4'd1;
        bus.cmd_b     = 4'd1;
        bus.rsp_ready = 1'b1;
        repeat (3) tick();
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        chk("rst_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        chk("rst_rsp_data",  16'(bus.rsp_data),  16'd0);
        chk("rst_rsp_carry", 16'(bus.rsp_carry), 16'd0);
        chk("rst_busy",      16'(bus.busy),      16'd0);
        chk("rst_cmd_ready", 16'(bus.cmd_ready), 16'd1);

        // Directed arithmetic cases.
        do_op(2'd0, 4'd9,  4'd8,  0, 1'b0);
        do_op(2'd1, 4'd3,  4'd5,  0, 1'b0);
        do_op(2'd2, 4'd15, 4'd15, 0, 1'b0);
        do_op(2'd2, 4'd0,  4'd9,  0, 1'b0);
        do_op(2'd3, 4'd13, 4'd4,  0, 1'b0);
        do_op(2'd3, 4'd7,  4'd0,  0, 1'b0);

        // Response backpressure with cmd_valid pulses while waiting.
        do_op(2'd2, 4'd6, 4'd7, 5, 1'b0);

        // Reset in cycle C+2 of a MUL: the operation must vanish.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd2;
        bus.cmd_a     = 4'd3;
        bus.cmd_b     = 4'd5;
        bus.rsp_ready = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        chk("midrst_rsp_data",  16'(bus.rsp_data),  16'd0);
        chk("midrst_rsp_carry", 16'(bus.rsp_carry), 16'd0);
        chk("midrst_busy",      16'(bus.busy),      16'd0);
        chk("midrst_cmd_ready", 16'(bus.cmd_ready), 16'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst_no_rsp", 16'(bus.rsp_valid), 16'd0);
        end
        do_op(2'd0, 4'd1, 4'd1, 0, 1'b0);

        // Back-to-back ADD, MUL, DIV with cmd_valid held high.
        nxt_op = 2'd2; nxt_a = 4'd5;  nxt_b = 4'd3;
        do_op(2'd0, 4'd12, 4'd7, 0, 1'b1);
        nxt_op = 2'd3; nxt_a = 4'd11; nxt_b = 4'd2;
        do_op(2'd2, 4'd5, 4'd3, 0, 1'b1);
        do_op(2'd3, 4'd11, 4'd2, 0, 1'b0);

        // Randomized operations and backpressure.
        for (int n = 0; n < 30; n++) begin
            do_op(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                  $urandom_range(0, 3), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
